uart_baud_gen: RTL and testbench

Parametrised baud-rate generator for the UART subsystem. It produces a one-cycle oversample strobe for the receiver, mid-bit and bit-boundary strobes, and a 50 % duty baud-rate square wave for legacy consumers. The divisor is programmable at run time, and the bit phase can be re-aligned to an incoming start bit. It sits between the system clock and the UART TX/RX engines.

---
 rtl/uart_pkg.sv | 19 +
 rtl/mod_counter.sv | 30 +++
 rtl/uart_baud_gen.sv | 115 +++++++++++
 tb/tb_uart_baud_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and divisor helper
// for the UART baud generator and its benches.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DIV_W_DEF      = 16;

  // Rounded clk cycles per oversample tick.
  function automatic int unsigned calc_div(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned os
  );
    longint unsigned step;
    step = baud * os;
    return 32'((clk_hz + step / 2) / step);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up counter with clear
// and a one-cycle wrap indication.
module mod_counter
  import uart_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // Wrap is suppressed whenever the count is being cleared.
  assign wrap = inc && !clr && !reset
             && (cnt >= modulus - W'(1));

  // Count up on inc, return to zero on wrap or clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable oversample, mid-bit,
// bit-boundary strobes and baud-rate square wave.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             resync,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic             baud_clk,
  output logic [DIV_W-1:0] div_q
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE + 1);

  localparam logic [DIV_W-1:0] DEFAULT_DIV =
    DIV_W'(calc_div(64'(CLK_HZ), 64'(BAUD),
                    64'(OVERSAMPLE)));

  localparam logic [PH_W-1:0] PH_MOD =
    PH_W'(OVERSAMPLE);

  localparam logic [PH_W-1:0] PH_MID =
    PH_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic             pend_valid;
  logic [DIV_W-1:0] div_cl;
  logic [DIV_W-1:0] os_cnt;
  logic [PH_W-1:0]  ph_cnt;
  logic             os_wrap;
  logic             ph_wrap;
  logic             clr;
  logic             apply;
  logic             mid;

  assign clr    = resync || !en;
  assign apply  = os_wrap || clr;
  assign mid    = os_wrap && (ph_cnt == PH_MID);
  assign div_q  = div_act;
  assign div_cl = (div_in < DIV_W'(2))
                ? DIV_W'(2) : div_in;

  mod_counter #(.W(DIV_W)) u_os (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc     (1'b1),
    .modulus (div_act),
    .cnt     (os_cnt),
    .wrap    (os_wrap)
  );

  mod_counter #(.W(PH_W)) u_ph (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc     (os_wrap),
    .modulus (PH_MOD),
    .cnt     (ph_cnt),
    .wrap    (ph_wrap)
  );

  // Hold a written divisor until the next safe point.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_act    <= DEFAULT_DIV;
      div_pend   <= DEFAULT_DIV;
      pend_valid <= 1'b0;
    end else if (apply) begin
      pend_valid <= 1'b0;
      if (div_wr) begin
        div_act <= div_cl;
      end else if (pend_valid) begin
        div_act <= div_pend;
      end
    end else if (div_wr) begin
      div_pend   <= div_cl;
      pend_valid <= 1'b1;
    end
  end

  // Registered strobes and the baud square wave.
  always_ff @(posedge clk) begin
    if (reset) begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      baud_clk <= 1'b0;
    end else begin
      os_tick  <= os_wrap;
      mid_tick <= mid;
      bit_tick <= ph_wrap;
      if (clr) begin
        baud_clk <= 1'b0;
      end else if (mid) begin
        baud_clk <= 1'b1;
      end else if (ph_wrap) begin
        baud_clk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: reference-model, table and
// directed-sequence checks for uart_baud_gen.
module tb_uart_baud_gen;

  localparam int DEF = 651;
  localparam int OS  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        resync = 1'b0;
  logic        div_wr = 1'b0;
  logic [15:0] div_in = '0;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic        baud_clk;
  logic [15:0] div_q;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  uart_baud_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .resync   (resync),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .baud_clk (baud_clk),
    .div_q    (div_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: ticks are events spaced d
  // edges apart after an anchor; tick number n
  // since the last phase restart gives mid/bit
  // and the baud level directly.
  int e_cnt = 0;
  int m_a = 0;
  int m_n = 0;
  int m_d = DEF;
  int m_pend = DEF;
  bit m_pv = 1'b0;
  bit e_os = 1'b0;
  bit e_mid = 1'b0;
  bit e_bit = 1'b0;
  bit e_baud = 1'b0;
  int e_div = DEF;

  always @(posedge clk) begin : model
    int  wv;
    bit  mclr;
    bit  tk;
    e_cnt++;
    e_os  = 1'b0;
    e_mid = 1'b0;
    e_bit = 1'b0;
    if (reset) begin
      m_a = e_cnt;
      m_n = 0;
      m_d = DEF;
      m_pv = 1'b0;
      e_baud = 1'b0;
    end else begin
      wv = (int'(div_in) < 2) ? 2 : int'(div_in);
      mclr = resync || !en;
      tk = !mclr && (e_cnt - m_a == m_d);
      if (mclr || tk) begin
        if (div_wr) m_d = wv;
        else if (m_pv) m_d = m_pend;
        m_pv = 1'b0;
      end else if (div_wr) begin
        m_pend = wv;
        m_pv = 1'b1;
      end
      if (mclr) begin
        m_a = e_cnt;
        m_n = 0;
        e_baud = 1'b0;
      end else if (tk) begin
        m_a = e_cnt;
        m_n++;
        e_os   = 1'b1;
        e_mid  = (m_n % OS) == OS / 2;
        e_bit  = (m_n % OS) == 0;
        e_baud = (m_n % OS) >= OS / 2;
      end
    end
    e_div = m_d;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model",
          {os_tick, mid_tick, bit_tick,
           baud_clk, div_q},
          {e_os, e_mid, e_bit, e_baud,
           16'(e_div)});
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      0: return os_tick;
      1: return mid_tick;
      2: return bit_tick;
      3: return baud_clk;
      default: return !baud_clk;
    endcase
  endfunction

  task automatic wait_hi(input int sel,
                         input int budget,
                         output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(sel)) begin
        at = cyc;
        return;
      end
    end
    nchk++;
    nerr++;
    $display("FAIL wait sel=%0d: got timeout expected event",
             sel);
  endtask

  task automatic wr_div(input int v);
    div_wr = 1'b1;
    div_in = 16'(v);
    @(negedge clk);
    div_wr = 1'b0;
  endtask

  typedef struct {
    int din;
    int exp;
  } vec_t;

  vec_t vecs[6];

  int t1, t2, t3, b1, b2, m1, r, f;
  int rs, gap_bad;

  initial begin
    vecs[0] = '{0, 2};
    vecs[1] = '{1, 2};
    vecs[2] = '{2, 2};
    vecs[3] = '{3, 3};
    vecs[4] = '{5, 5};
    vecs[5] = '{65535, 65535};

    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_ticks",
        {os_tick, mid_tick, bit_tick, baud_clk}, 0);
    chk("reset_div", div_q, DEF);
    reset = 1'b0;
    en = 1'b1;

    // default cadence
    wait_hi(0, 2000, t1);
    wait_hi(0, 2000, t2);
    chk("os_period_def", t2 - t1, 651);
    wait_hi(2, 20000, b1);
    wait_hi(1, 20000, m1);
    chk("mid_after_bit", m1 - b1, 5208);
    wait_hi(2, 20000, b2);
    chk("bit_period_def", b2 - b1, 10416);
    wait_hi(3, 20000, r);
    chk("baud_low", r - b2, 5208);
    wait_hi(4, 20000, f);
    chk("baud_high", f - r, 5208);

    // write 4 mid-period
    wait_hi(0, 2000, t1);
    repeat (100) @(negedge clk);
    wr_div(4);
    wait_hi(0, 2000, t2);
    chk("period_before_apply", t2 - t1, 651);
    chk("div_after_wrap", div_q, 4);
    wait_hi(0, 100, t3);
    chk("os_period_4", t3 - t2, 4);

    // clamp 1 -> 2
    wr_div(1);
    repeat (6) @(negedge clk);
    chk("div_clamped", div_q, 2);
    wait_hi(0, 100, t1);
    wait_hi(0, 100, t2);
    chk("os_period_2", t2 - t1, 2);
    wait_hi(2, 200, b1);
    wait_hi(2, 200, b2);
    chk("bit_period_2", b2 - b1, 32);

    // resync at an arbitrary phase, div 4
    wr_div(4);
    repeat (10) @(negedge clk);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    resync = 1'b1;
    rs = cyc + 1;
    @(negedge clk);
    resync = 1'b0;
    chk("resync_quiet",
        {os_tick, mid_tick, bit_tick, baud_clk}, 0);
    wait_hi(0, 100, t1);
    chk("resync_os", t1 - rs, 4);
    wait_hi(1, 100, m1);
    chk("resync_mid", m1 - rs, 32);
    wait_hi(2, 100, b1);
    chk("resync_bit", b1 - rs, 64);

    // en low gap with pending divisor 8
    wait_hi(0, 100, t1);
    div_wr = 1'b1;
    div_in = 16'd8;
    @(negedge clk);
    div_wr = 1'b0;
    en = 1'b0;
    gap_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({os_tick, mid_tick, bit_tick,
           baud_clk} != 4'd0 || div_q != 16'd8)
        gap_bad++;
    end
    chk("en_gap_quiet", gap_bad, 0);
    chk("en_gap_div", div_q, 8);
    en = 1'b1;
    rs = cyc;
    wait_hi(0, 100, t1);
    chk("en_rise_os", t1 - rs, 8);

    // reset mid-bit
    wait_hi(1, 500, m1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rs = cyc + 1;
    @(negedge clk);
    reset = 1'b0;
    chk("midbit_reset_ticks",
        {os_tick, mid_tick, bit_tick, baud_clk}, 0);
    chk("midbit_reset_div", div_q, DEF);
    wait_hi(0, 2000, t1);
    chk("reset_first_os", t1 - rs, 651);
    wait_hi(0, 2000, t2);
    chk("reset_os_period", t2 - t1, 651);

    // divisor write table, applied via resync
    foreach (vecs[i]) begin
      wr_div(vecs[i].din);
      resync = 1'b1;
      @(negedge clk);
      resync = 1'b0;
      chk($sformatf("tbl_div_%0d", i),
          div_q, vecs[i].exp);
    end

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 499) == 0);
      resync = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      div_wr = ($urandom_range(0, 29) == 0);
      div_in = 16'($urandom_range(0, 9));
    end
    @(negedge clk);
    reset = 1'b0;
    resync = 1'b0;
    div_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
